data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
Parametrised, byte-addressed, little-endian data memory for the single-cycle/multi-cycle datapath labs. Successor to the fixed 64-bit, 64-byte data memory. Adds byte/half/word/double access sizes with sign/zero extension, a valid/ready request handshake, configurable read latency via a wait-state counter, and bounds/size error reporting. Sits between the ALU/address path and the write-back mux.

Parameters:
DATA_W, 64, data bus width in bits; 32 or 64 only.
DEPTH, 64, memory size in bytes; power of two, ≥ DATA_W/8.
ADDR_W, 64, request address width in bits.
LATENCY, 1, cycles from acceptance to response; ≥1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0; ignored on stores
req_addr  input  ADDR_W  byte address of the lowest byte
req_wdata  input  DATA_W  store data, low 2^size bytes used
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors
rsp_error  output  1  request rejected (qualified by rsp_valid)

Behaviour:
- Clock is clk. Reset is asynchronous and active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, state=IDLE, counter=0, byte i of memory = i mod 256.
- Reset mid-operation aborts the pending response. No rsp_valid is emitted, and memory returns to the reset pattern.
- FSM: IDLE, BUSY.
  - req_ready = (state==IDLE).
  - Acceptance occurs at edge E0 when req_valid && req_ready.
  - On acceptance: IDLE->BUSY, counter := LATENCY-1.
  - In BUSY, counter decrements each edge. At the edge where counter==0: BUSY->IDLE and rsp_valid:=1 for exactly one cycle.
  - Net timing: rsp_valid is high in the cycle after edge E0+LATENCY, and req_ready is low for LATENCY cycles.
  - Maximum throughput is one request per LATENCY+1 cycles. There is no response backpressure.
- nbytes = 2^req_size.
- Error when either:
  - req_size > log2(DATA_W/8) (e.g. size 3 when DATA_W=32), or
  - req_addr + nbytes > DEPTH. Compute this sum in ADDR_W+1 bits so there is no wrap-around.
- On error: no memory change, rsp_error=1, rsp_rdata=0.
- Any alignment is legal. Misaligned accesses are handled byte-wise with no penalty.
- Store: bytes req_wdata[8k+7:8k] are written to addr+k for k<nbytes, committed at E0. rsp_valid still pulses as an ack with rsp_rdata=0.
- Load: bytes are snapshotted at E0 and held in a response register. rsp_rdata = {extension, bytes addr+nbytes-1 .. addr}.
  - Extension bit is the top loaded bit when req_unsigned=0, else 0.
  - For size==max, req_unsigned has no effect.
- rsp_rdata and rsp_error hold their values until the next response.
- Request inputs are sampled only at acceptance and are ignored while BUSY.

Decomposition:
- Package data_mem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum IDLE/BUSY;
  - function max_size(DATA_W).
- Sub-module mem_load_align: combinational. Takes the raw byte vector, size and unsigned flag, and returns the extended DATA_W result. It is reused by the verification reference model.

Test Plan (DATA_W=64, DEPTH=64, LATENCY=1 unless stated):
- After reset, load size 3 at addr 8 -> rsp_valid one cycle after accept, rsp_rdata=0x0F0E0D0C0B0A0908, rsp_error=0.
- Store byte 0x80 at addr 5, then load byte signed at 5 -> 0xFFFFFFFFFFFFFF80. The same load unsigned -> 0x0000000000000080.
- Store half 0xBEEF at addr 3 (misaligned), then load word signed at addr 2 -> 0x0000000005BEEF02.
- Load double at addr 60 -> rsp_error=1, rsp_rdata=0. Then store double 0xFFFF... at addr 57 -> rsp_error=1. Then load byte at 57 -> 0x39 (memory unchanged).
- LATENCY=3, req_valid held high with loads at 0, 8, 16 -> accepts spaced 4 cycles apart, req_ready low 3 cycles after each, rsp_valid 3 cycles after each accept edge, data 0x0706050403020100 / 0x0F0E... / 0x1716....
- DATA_W=32: load size 3 -> error. Separately, store word at addr 0 then assert reset while BUSY -> rsp_valid stays 0, outputs cleared, and a load byte at 0 after release returns 0x00.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings for the byte-addressed data memory controller.
package data_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Largest legal size encoding for a given data bus width.
  function automatic int max_size(input int data_w);
    return (data_w == 32) ? 2 : 3;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_load_align.sv
// Combinational load extender: raw little-endian bytes in, sign/zero-extended word out.
module mem_load_align
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] raw_bytes,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] rdata
);

  logic sign_bit;
  logic ext_bit;
  int   nbits;

  always_comb begin
    sign_bit = 1'b0;
    case (size)
      SZ_B:    sign_bit = raw_bytes[7];
      SZ_H:    sign_bit = raw_bytes[15];
      SZ_W:    sign_bit = raw_bytes[31];
      default: sign_bit = raw_bytes[DATA_W-1];
    endcase
    ext_bit = sign_bit & ~is_unsigned;
    nbits   = 8 << size;
    rdata   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rdata[i] = (i < nbits) ? raw_bytes[i] : ext_bit;
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with valid/ready requests and fixed read latency.
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   BUSY  | request accepted, counting down to the response pulse
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  logic [7:0]        mem [DEPTH];
  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [DATA_W-1:0] hold_rdata;
  logic              hold_error;

  logic [3:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              req_error;
  logic [DATA_W-1:0] raw_bytes;
  logic [DATA_W-1:0] load_data;

  // End address is one bit wider than the request so huge addresses cannot wrap into range.
  always_comb begin
    nbytes    = 4'd1 << req_size;
    end_addr  = {1'b0, req_addr} + (ADDR_W+1)'(nbytes);
    req_error = (int'(req_size) > max_size(DATA_W)) ||
                (end_addr > (ADDR_W+1)'(DEPTH));
  end

  always_comb begin
    raw_bytes = '0;
    for (int k = 0; k < NB; k++) begin
      raw_bytes[8*k +: 8] = mem[req_addr[IDX_W-1:0] + IDX_W'(k)];
    end
  end

  mem_load_align #(.DATA_W(DATA_W)) u_load_align (
    .raw_bytes   (raw_bytes),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .rdata       (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      counter    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_error  <= 1'b0;
      hold_rdata <= '0;
      hold_error <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'(i);
      end
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state      <= BUSY;
            req_ready  <= 1'b0;
            counter    <= CNT_INIT;
            hold_error <= req_error;
            hold_rdata <= (req_error || req_write) ? '0 : load_data;
            // Stores commit at acceptance; the later response is only an ack.
            if (req_write && !req_error) begin
              for (int k = 0; k < NB; k++) begin
                if (k < int'(nbytes)) begin
                  mem[req_addr[IDX_W-1:0] + IDX_W'(k)] <= req_wdata[8*k +: 8];
                end
              end
            end
          end
        end
        BUSY: begin
          if (counter == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= hold_rdata;
            rsp_error <= hold_error;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
